// File: rtl/opc5_bus_pkg.sv
// opc5_bus_pkg: shared I/O window offsets, status bit positions and CPU opcode constants
package opc5_bus_pkg;

    typedef enum logic [1:0] {
        IO_CONS = 2'd0,
        IO_STAT = 2'd1,
        IO_HALT = 2'd2,
        IO_RSVD = 2'd3
    } io_off_e;

    localparam int ST_HALT  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [15:0] HALT_OP = 16'hC000;

endpackage

// File: rtl/opc5_bus_responder_if.sv
// opc5_bus_responder_if: OPC5 CPU bus plus console and status signals between CPU side and responder
interface opc5_bus_responder_if;

    logic [15:0] address;
    logic        rnw;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        halt;
    logic        err;

    modport master (
        output address, rnw, data_in, cons_ready,
        input  data_out, data_oe, cons_data, cons_valid, halt, err
    );

    modport slave (
        input  address, rnw, data_in, cons_ready,
        output data_out, data_oe, cons_data, cons_valid, halt, err
    );

endinterface

// File: rtl/opc5_cons_fifo.sv
// opc5_cons_fifo: circular console byte FIFO with sticky overflow, head held in registered storage
module opc5_cons_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    input  logic       i_clr_ovf,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        r_ovf;
    logic        w_push;
    logic        w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_ovf   = r_ovf;
    assign w_pop   = i_pop && !o_empty;
    // a push arriving while full is dropped even if a pop frees a slot on the same edge
    assign w_push  = i_push && !o_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + (AW+1)'(1);
            end
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
            r_ovf <= (i_push && o_full) || (r_ovf && !i_clr_ovf);
        end
    end

endmodule

// File: rtl/opc5_bus_responder.sv
// opc5_bus_responder: OPC5 bus RAM + I/O window (console FIFO, status, halt); OPC5_BUS_PROTECT_EN adds RAM write protection
module opc5_bus_responder
    import opc5_bus_pkg::*;
#(
    parameter int          MEM_AW     = 12,
    parameter logic [15:0] IO_BASE    = 16'hFE00,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] ROM_TOP    = 16'h0100
) (
    input  logic               clk,
    input  logic               reset,
    opc5_bus_responder_if.slave bus
);

`ifdef OPC5_BUS_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic [15:0] r_ram [2**MEM_AW];
    logic        r_halt;
    logic        r_err;
    logic        w_io;
    io_off_e     w_off;
    logic        w_wr;
    logic        w_ram_wr;
    logic        w_prot_hit;
    logic        w_full;
    logic        w_empty;
    logic        w_ovf;
    logic [15:0] w_status;

    assign w_io       = bus.address[15:2] == IO_BASE[15:2];
    assign w_off      = io_off_e'(bus.address[1:0]);
    assign w_wr       = !bus.rnw && !reset;
    assign w_ram_wr   = w_wr && !w_io;
    // compares the full CPU address, so aliases above MEM_AW stay writable
    assign w_prot_hit = PROT_EN && (bus.address < ROM_TOP);

    opc5_cons_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_wr && w_io && w_off == IO_CONS),
        .i_data    (bus.data_in[7:0]),
        .i_pop     (bus.cons_ready),
        .i_clr_ovf (w_wr && w_io && w_off == IO_STAT),
        .o_data    (bus.cons_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ovf     (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (w_ram_wr && !w_prot_hit) r_ram[bus.address[MEM_AW-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halt <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_halt <= r_halt || (w_wr && w_io && w_off == IO_HALT);
            r_err  <= r_err || (w_ram_wr && w_prot_hit);
        end
    end

    always_comb begin
        w_status          = '0;
        w_status[ST_HALT] = r_halt;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL] = w_full;
        w_status[ST_OVF]  = w_ovf;
    end

    assign bus.data_out   = !w_io             ? r_ram[bus.address[MEM_AW-1:0]] :
                            w_off == IO_STAT  ? w_status :
                            w_off == IO_HALT  ? {15'b0, r_halt} : 16'h0000;
    assign bus.data_oe    = bus.rnw && !reset;
    assign bus.cons_valid = !w_empty;
    assign bus.halt       = r_halt;
    assign bus.err        = r_err;

endmodule
